// File: rtl/restoring_divider_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;

  localparam int DIV_DEF_N = 16;
  localparam int DIV_CNT_W = $clog2(DIV_DEF_N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Counter must hold the value N itself, hence N+1 codes.
  function automatic int div_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// Request/result bundle for restoring_divider. The remainder signal exists
// only when RESTORING_DIV_REM_EN is defined.
interface restoring_divider_if
  import div_pkg::*;
#(
  parameter int N = DIV_DEF_N
);

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
`ifdef RESTORING_DIV_REM_EN
  logic [N-1:0] remainder;
`endif
  logic         div_zero;

`ifdef RESTORING_DIV_REM_EN
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, div_zero
  );
`endif

endinterface

// File: rtl/restoring_divider_ripple_subtractor.sv
// Combinational W-bit ripple subtractor: diff_o = a_i - b_i, borrow_o is the
// borrow out of the MSB (set when a_i < b_i).
module ripple_subtractor #(
  parameter int W = 17
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W:0] borrow_s;

  // Full-subtractor chain, LSB first.
  always_comb begin
    borrow_s = '0;
    diff_o   = '0;
    for (int i = 0; i < W; i++) begin
      diff_o[i]     = a_i[i] ^ b_i[i] ^ borrow_s[i];
      borrow_s[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow_s[i]);
    end
    borrow_o = borrow_s[W];
  end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock through a
// shared N+1-bit ripple subtractor. RESTORING_DIV_REM_EN exposes the remainder.
module restoring_divider
  import div_pkg::*;
#(
  parameter int N = DIV_DEF_N
) (
  input logic                clk,
  input logic                rst_n,
  restoring_divider_if.slave bus
);

  localparam int CW = div_cnt_w(N);

  div_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]   r_q, r_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] divisor_q, divisor_d;
  logic [N-1:0] quotient_q, quotient_d;
  logic         dz_next_q, dz_next_d;
  logic         div_zero_q, div_zero_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
`ifdef RESTORING_DIV_REM_EN
  logic [N-1:0] rem_q, rem_d;
`endif

  logic [N:0]   t_s;
  logic [N:0]   diff_s;
  logic         borrow_s;
  logic         unused_s;

  // A restored remainder is always below the divisor, so R's top bit stays 0.
  assign unused_s = r_q[N];
  assign t_s      = {r_q[N-1:0], q_q[N-1]};

  ripple_subtractor #(
    .W (N + 1)
  ) u_sub (
    .a_i      (t_s),
    .b_i      ({1'b0, divisor_q}),
    .diff_o   (diff_s),
    .borrow_o (borrow_s)
  );

  // Next-state, datapath and result-register logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    q_d        = q_q;
    divisor_d  = divisor_q;
    quotient_d = quotient_q;
    dz_next_d  = dz_next_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
`ifdef RESTORING_DIV_REM_EN
    rem_d      = rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          r_d       = '0;
          q_d       = bus.dividend;
          divisor_d = bus.divisor;
          cnt_d     = CW'(N);
          dz_next_d = (bus.divisor == '0);
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (borrow_s) begin
          r_d = t_s;
          q_d = {q_q[N-2:0], 1'b0};
        end else begin
          r_d = diff_s;
          q_d = {q_q[N-2:0], 1'b1};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        quotient_d = q_q;
        div_zero_d = dz_next_q;
        done_d     = 1'b1;
`ifdef RESTORING_DIV_REM_EN
        rem_d      = r_q[N-1:0];
`endif
        // Results are captured above before a back-to-back reload overwrites Q/R.
        if (bus.start) begin
          state_d   = RUN;
          r_d       = '0;
          q_d       = bus.dividend;
          divisor_d = bus.divisor;
          cnt_d     = CW'(N);
          dz_next_d = (bus.divisor == '0);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      divisor_q  <= '0;
      quotient_q <= '0;
      dz_next_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef RESTORING_DIV_REM_EN
      rem_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      q_q        <= q_d;
      divisor_q  <= divisor_d;
      quotient_q <= quotient_d;
      dz_next_q  <= dz_next_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
`ifdef RESTORING_DIV_REM_EN
      rem_q      <= rem_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.quotient = quotient_q;
  assign bus.div_zero = div_zero_q;
`ifdef RESTORING_DIV_REM_EN
  assign bus.remainder = rem_q;
`endif

endmodule
